// File: rtl/muon_display_pkg.sv
// Shared digit width, default digit count and converter state
// encoding for the muon display path.
package muon_display_pkg;

    localparam int BCD_W          = 4;
    localparam int DEF_NUM_DIGITS = 8;

    localparam logic [BCD_W-1:0] BCD_NINE = 4'h9;
    localparam logic [BCD_W*DEF_NUM_DIGITS-1:0] NINE_FILL =
        {DEF_NUM_DIGITS{BCD_NINE}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: values of five or more get +3
// so the following left shift carries into the next decade.
module bcd_add3
    import muon_display_pkg::*;
(
    input  logic [BCD_W-1:0] nib,
    output logic [BCD_W-1:0] fix
);

    assign fix = (nib >= 4'd5) ? nib + 4'd3 : nib;

endmodule

// File: rtl/bcd_split_converter.sv
// Iterative binary-to-BCD converter; commits the full result in one
// edge so the display never shows partial digits.
module bcd_split_converter
    import muon_display_pkg::*;
#(
    parameter int BIN_WIDTH  = 27,
    parameter int NUM_DIGITS = DEF_NUM_DIGITS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [BIN_WIDTH-1:0]          bin_in,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow,
    output logic [BCD_W*NUM_DIGITS/2-1:0] digits_A,
    output logic [BCD_W*NUM_DIGITS/2-1:0] digits_B
);

    localparam int SW = BCD_W * NUM_DIGITS;
    localparam int CW = $clog2(BIN_WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(BIN_WIDTH);
    localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;

    state_t               state;
    logic [SW-1:0]        scratch;
    logic [SW-1:0]        adj;
    logic [BIN_WIDTH-1:0] binreg;
    logic [CW-1:0]        cnt;
    logic                 ovf_pend;
    logic                 ovf_in;

    assign ovf_in = 64'(bin_in) > MAX_VAL;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nib (scratch[g*BCD_W +: BCD_W]),
            .fix (adj[g*BCD_W +: BCD_W])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            scratch  <= '0;
            binreg   <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            digits_A <= '0;
            digits_B <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        binreg   <= bin_in;
                        scratch  <= '0;
                        cnt      <= CNT_LOAD;
                        ovf_pend <= ovf_in;
                        busy     <= 1'b1;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // carry out of the top nibble only happens on overflow
                    scratch <= {adj[SW-2:0], binreg[BIN_WIDTH-1]};
                    binreg  <= binreg << 1;
                    cnt     <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    if (ovf_pend) begin
                        {digits_A, digits_B} <= {NUM_DIGITS{BCD_NINE}};
                    end else begin
                        {digits_A, digits_B} <= scratch;
                    end
                    overflow <= ovf_pend;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_split_converter.sv
// Scoreboard bench for bcd_split_converter: directed vectors with
// hand-computed digits, checked by an independent done monitor.
module tb_bcd_split_converter;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [26:0] bin_in;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] digits_A;
    logic [15:0] digits_B;

    exp_t sb[$];
    int   n_vec;
    int   n_bad;
    int   n_done;
    int   cyc;

    bcd_split_converter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .digits_A (digits_A),
        .digits_B (digits_B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every done pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("digits_A", {16'd0, digits_A}, {16'd0, e.a});
                chk("digits_B", {16'd0, digits_B}, {16'd0, e.b});
                chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    task automatic push(input logic [15:0] a, input logic [15:0] b,
                        input logic ovf);
        exp_t e;
        e.a   = a;
        e.b   = b;
        e.ovf = ovf;
        sb.push_back(e);
    endtask

    // counts edges after the accept edge until done shows
    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!done && cycles < 40);
        if (!done) begin
            chk("done_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic convert(input logic [26:0] v, input logic [15:0] a,
                           input logic [15:0] b, input logic ovf);
        int c;
        push(a, b, ovf);
        start  = 1'b1;
        bin_in = v;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(c);
        chk("latency", c, 28);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c;
        int d0;
        int t1;
        int t2;
        n_vec  = 0;
        n_bad  = 0;
        n_done = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_ovf", {31'd0, overflow}, 32'd0);
        chk("reset_digits", {digits_A, digits_B}, 32'd0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        convert(27'd71154937, 16'h7115, 16'h4937, 1'b0);
        convert(27'd0, 16'h0000, 16'h0000, 1'b0);
        convert(27'd99999999, 16'h9999, 16'h9999, 1'b0);
        convert(27'd100000000, 16'h9999, 16'h9999, 1'b1);
        convert(27'd42, 16'h0000, 16'h0042, 1'b0);

        // start pulse mid-conversion must be dropped
        d0 = n_done;
        push(16'h1234, 16'h5678, 1'b0);
        start  = 1'b1;
        bin_in = 27'd12345678;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("busy_mid", {31'd0, busy}, 32'd1);
        start  = 1'b1;
        bin_in = 27'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(c);
        repeat (40) @(posedge clk);
        #1;
        chk("single_done", n_done - d0, 1);

        // asynchronous reset aborts a conversion
        d0     = n_done;
        start  = 1'b1;
        bin_in = 27'd87654321;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_ovf", {31'd0, overflow}, 32'd0);
        chk("arst_digits", {digits_A, digits_B}, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("aborted_no_done", n_done - d0, 0);
        convert(27'd87654321, 16'h8765, 16'h4321, 1'b0);

        // start held high: one accept per 29 cycles
        push(16'h0000, 16'h0001, 1'b0);
        start  = 1'b1;
        bin_in = 27'd1;
        @(posedge clk);
        #1;
        push(16'h1000, 16'h0000, 1'b0);
        bin_in = 27'd10000000;
        wait_done(c);
        chk("b2b_lat0", c, 28);
        t1 = cyc;
        @(posedge clk);
        #1;
        push(16'h0006, 16'h5535, 1'b0);
        bin_in = 27'd65535;
        wait_done(c);
        chk("b2b_lat1", c, 28);
        t2 = cyc;
        chk("b2b_spacing", t2 - t1, 29);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(c);
        chk("b2b_lat2", c, 28);
        repeat (3) @(posedge clk);
        #1;

        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_split_converter.md
# bcd_split_converter

Sequential binary-to-BCD converter that sits directly upstream of the dual 7-segment display controller. It takes one binary measurement, such as a muon decay time in clock ticks, and converts it by iterative double-dabble (shift-add-3) into eight packed BCD digits. The result is presented as two 16-bit fields, `digits_A` (upper four digits) and `digits_B` (lower four digits), which are wired straight to the display controller's inputs. Outputs change only on a completed conversion, so the display never shows a partial result.

## Interface
- `BIN_WIDTH`, 27: width of the binary input; 2^27 covers 0..99,999,999.
- `NUM_DIGITS`, 8: BCD digits produced; must be even. Each half is NUM_DIGITS/2 digits.
- `clk`  in  1: system clock (100 MHz in the muon design).
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a conversion of `bin_in`; sampled only while idle.
- `bin_in`  in  BIN_WIDTH: unsigned binary value; sampled on the edge where `start` is accepted.
- `busy`  out  1: conversion in progress.
- `done`  out  1: one-cycle pulse when new digits are committed.
- `overflow`  out  1: the committed value exceeded 10^NUM_DIGITS−1.
- `digits_A`  out  4·NUM_DIGITS/2: most significant digits, packed BCD, MSD in the top nibble.
- `digits_B`  out  4·NUM_DIGITS/2: least significant digits, packed BCD.

## Operation
- **States:**
  - IDLE: wait for `start`.
  - SHIFT: run the double-dabble iterations.
  - COMMIT: write the result to the outputs.
- **IDLE → SHIFT** on `start`=1:
  - latch `bin_in` into a shift register;
  - clear the BCD scratch register;
  - load the iteration counter with BIN_WIDTH;
  - evaluate overflow (`bin_in` > 10^NUM_DIGITS−1) and latch it as a pending flag.
- **SHIFT**, once per cycle:
  - every scratch nibble ≥5 gets +3 (all nibbles in parallel, combinationally);
  - then {scratch, binreg} shifts left by 1;
  - the counter decrements.
- **SHIFT → COMMIT** when the counter reaches 0, i.e. after exactly BIN_WIDTH shifts.
- **COMMIT:**
  - write the scratch register to `digits_A`/`digits_B`, or all nibbles = 4'h9 if the pending overflow flag is set;
  - update `overflow` with the pending flag;
  - pulse `done`;
  - return to IDLE.
- `start` while busy (SHIFT or COMMIT) is ignored; it is not queued.
- `start` held high continuously restarts a conversion on the first IDLE cycle after each COMMIT.
- `digits_A`, `digits_B` and `overflow` hold their last committed values between conversions.
- Scratch width is 4·NUM_DIGITS. Any carry out of the top nibble is discarded; it only occurs on overflow, which is masked by saturation.
- **Reset** (`rst_n`=0, any time, including mid-conversion):
  - state IDLE;
  - `busy`=0, `done`=0, `overflow`=0;
  - `digits_A`=0, `digits_B`=0;
  - scratch, shift register and counter cleared.
  - An aborted conversion never commits.

## Timing
- `start` is accepted at edge E0. SHIFT occupies edges E1..E(BIN_WIDTH). COMMIT is at edge E(BIN_WIDTH+1).
- `busy` is high from E0 until E(BIN_WIDTH+1), then low.
- `done` is high for exactly the one cycle following E(BIN_WIDTH+1).
- New digits and `overflow` are visible in that same cycle.
- Latency, start to done: BIN_WIDTH+1 cycles (28 at default).
- Minimum spacing between accepted starts: BIN_WIDTH+2 cycles.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package `muon_display_pkg` holds:
  - `BCD_W`=4;
  - default `NUM_DIGITS`=8;
  - the state enum (IDLE, SHIFT, COMMIT);
  - the BCD nine-fill constant.
  - The display controller reuses the digit width and count from this package.
- Sub-module `bcd_add3`: a combinational 4-bit nibble correction (in ≥5 → in+3), instantiated NUM_DIGITS times by generate.

## Test plan
- **Normal value:** `bin_in`=71,154,937, `start` pulse → `done` 28 cycles later; `digits_A`=16'h7115, `digits_B`=16'h4937, `overflow`=0. These digits drive the display bench pattern.
- **Extremes:**
  - `bin_in`=0 → both halves 16'h0000;
  - then `bin_in`=99,999,999 → both halves 16'h9999, `overflow`=0.
- **Overflow:** `bin_in`=100,000,000 → both halves 16'h9999, `overflow`=1. A following conversion of 42 clears it: `digits_B`=16'h0042, `overflow`=0.
- **Ignored start:** convert 12,345,678, and assert `start` with `bin_in`=1 at cycle 10 while `busy`. Result is `digits_A`=16'h1234, `digits_B`=16'h5678, and exactly one `done` pulse.
- **Reset mid-conversion:** drop `rst_n` at cycle 15 of converting 87,654,321. All outputs read 0 immediately (asynchronous) and no `done` pulse occurs. After release, a fresh start converts correctly.
- **Back-to-back:** `start` held high with `bin_in` changing → `done` pulses every 29 cycles, each matching the `bin_in` sampled at its accept edge.
